// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and key-index width helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } kp_state_e;

    // Width of a key index row*COLS+col; never narrower than one bit.
    function automatic int key_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through event FIFO; the head is visible on data_o whenever valid_o is high.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: rotates a one-hot column drive, debounces a single pressed key
// and queues one key-index event per debounced press.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DWELL_CYCLES = 27_000,
    parameter int DB_SAMPLES   = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int KW          = key_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [ROWS-1:0] filas_raw,
    output logic [COLS-1:0] columnas,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow,
    output kp_state_e       dbg_state
);
    // Event handshake: the head event transfers on a rising clk edge where key_valid && key_ready;
    // key_code is stable while key_valid is high and not yet accepted.
    localparam int TW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int DW = $clog2(DB_SAMPLES + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [ROWS-1:0] sync1_q, sync2_q;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;

    kp_state_e       state_q;
    logic [COLS-1:0] columnas_q;
    logic [ROWS-1:0] row_q;
    logic [KW-1:0]   key_q;
    logic [DW-1:0]   db_cnt_q;
    logic            key_held_q;
    logic            overflow_q;

    logic            rows_zero, rows_one, row_match, last_sample;
    logic [COLS-1:0] columnas_rot;
    logic [RW-1:0]   row_idx;
    logic [CW-1:0]   col_idx;
    logic [KW-1:0]   key_calc;
    logic            push, pop, fifo_full;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= filas_raw;
            sync2_q <= sync1_q;
        end
    end

    assign tick       = (tick_cnt_q == TW'(DWELL_CYCLES - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) tick_cnt_q <= '0;
        else          tick_cnt_q <= tick_cnt_d;
    end

    assign rows_zero    = (sync2_q == '0);
    assign rows_one     = !rows_zero && ((sync2_q & (sync2_q - ROWS'(1))) == '0);
    assign row_match    = (sync2_q == row_q);
    assign last_sample  = (db_cnt_q == DW'(DB_SAMPLES - 1));
    assign columnas_rot = {columnas_q[COLS-2:0], columnas_q[COLS-1]};

    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int i = 0; i < ROWS; i++) if (sync2_q[i])    row_idx = RW'(i);
        for (int j = 0; j < COLS; j++) if (columnas_q[j]) col_idx = CW'(j);
        key_calc = KW'(int'(row_idx) * COLS + int'(col_idx));
    end

    assign push = tick && (state_q == ST_CONFIRM) && row_match && last_sample;
    assign pop  = key_valid && key_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_SCAN;
            columnas_q <= COLS'(1);
            row_q      <= '0;
            key_q      <= '0;
            db_cnt_q   <= '0;
            key_held_q <= 1'b0;
        end else if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    // Multi-row samples are ghosting and are scanned past like an idle column.
                    if (rows_one) begin
                        row_q    <= sync2_q;
                        key_q    <= key_calc;
                        db_cnt_q <= '0;
                        state_q  <= ST_CONFIRM;
                    end else begin
                        columnas_q <= columnas_rot;
                    end
                end
                ST_CONFIRM: begin
                    if (!row_match) begin
                        db_cnt_q <= '0;
                        state_q  <= ST_SCAN;
                    end else if (last_sample) begin
                        db_cnt_q   <= '0;
                        key_held_q <= 1'b1;
                        state_q    <= ST_HELD;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (rows_zero) begin
                        db_cnt_q <= '0;
                        state_q  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if ((sync2_q & row_q) != '0) begin
                        db_cnt_q <= '0;
                        state_q  <= ST_HELD;
                    end else if (!rows_zero) begin
                        db_cnt_q <= '0;
                    end else if (last_sample) begin
                        db_cnt_q   <= '0;
                        key_held_q <= 1'b0;
                        columnas_q <= columnas_rot;
                        state_q    <= ST_SCAN;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                       overflow_q <= 1'b0;
        else if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KW)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push_i  (push),
        .data_i  (key_q),
        .pop_i   (key_ready),
        .data_o  (key_code),
        .valid_o (key_valid),
        .full_o  (fifo_full)
    );

    assign columnas  = columnas_q;
    assign key_held  = key_held_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl on a 4x4 matrix with DWELL_CYCLES=8, DB_SAMPLES=3, FIFO_DEPTH=4.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;
    kp_state_e  dbg_state;

    logic [15:0] pressed;
    int          cyc;
    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];

    keypad_scan_ctrl #(
        .ROWS         (4),
        .COLS         (4),
        .DWELL_CYCLES (8),
        .DB_SAMPLES   (3),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .filas_raw (filas_raw),
        .columnas  (columnas),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; a dwell tick edge is the one where cyc becomes a multiple of 8.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Keypad matrix: a pressed key shorts its column drive onto its row line.
    always_comb begin
        filas_raw = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && columnas[c]) filas_raw[r] = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_tick();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 8 != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset   = 1'b0;
        key_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid",    key_valid, 0);
        chk("rst_code",     key_code,  0);
        chk("rst_columnas", columnas,  4'b0001);
        chk("rst_held",     key_held,  0);
        chk("rst_overflow", overflow,  0);
        chk("rst_state",    dbg_state, ST_SCAN);
        n_reset = 1'b1;
    endtask

    task automatic pop_one(input logic [3:0] exp_code);
        chk("pop_valid", key_valid, 1);
        chk("pop_code",  key_code,  exp_code);
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        key_ready = 1'b0;
    endtask

    // Keys 0,5,10,15,4 each sit on the column being driven when they are pressed,
    // so every key confirms on the next tick, pushes 3 ticks later and releases 4 ticks after that.
    task automatic run_five(input bit pop_on_fifth);
        logic [3:0] keys [5];
        keys = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4};
        pressed = '0;
        exp_q.delete();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("five_col_at_press", columnas, 4'b0001 << (i % 4));
            pressed[keys[i]] = 1'b1;
            repeat (3) next_tick();
            chk("five_no_early_push_held", key_held, 0);
            if (i == 4 && pop_on_fifth) begin
                repeat (7) @(posedge clk);
                #1;
                key_ready = 1'b1;
                @(posedge clk);
                #1;
                key_ready = 1'b0;
                void'(exp_q.pop_front());
                exp_q.push_back(keys[i]);
            end else begin
                next_tick();
                if (i < 4) exp_q.push_back(keys[i]);
            end
            chk("five_held", key_held, 1);
            chk("five_overflow", overflow, (i == 4 && !pop_on_fifth) ? 1 : 0);
            pressed[keys[i]] = 1'b0;
            repeat (4) next_tick();
            chk("five_released", key_held, 0);
        end
        while (exp_q.size() > 0) pop_one(exp_q.pop_front());
        chk("five_drained", key_valid, 0);
        chk("five_overflow_final", overflow, pop_on_fifth ? 0 : 1);
    endtask

    initial begin
        n_reset   = 1'b0;
        key_ready = 1'b0;
        pressed   = '0;

        // Single press of row 1 / column 2 -> key 6.
        do_reset();
        pressed[6] = 1'b1;
        repeat (5) next_tick();
        chk("single_no_early", key_valid, 0);
        chk("single_state_confirm", dbg_state, ST_CONFIRM);
        next_tick();
        chk("single_valid", key_valid, 1);
        chk("single_code",  key_code,  6);
        chk("single_held",  key_held,  1);
        chk("single_col_frozen", columnas, 4'b0100);
        pressed[6] = 1'b0;
        repeat (3) next_tick();
        chk("single_held_debouncing", key_held, 1);
        next_tick();
        chk("single_released", key_held, 0);
        chk("single_col_rotated", columnas, 4'b1000);
        pop_one(4'd6);
        chk("single_one_event", key_valid, 0);

        // Bounce on row 2 / column 0 -> key 8, sampled 1,0,1,0,1 then stable.
        pressed = '0;
        do_reset();
        pressed[8] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            next_tick();
            chk("bounce_no_push", key_valid, 0);
            chk("bounce_col",     columnas,  4'b0001);
            if (t <= 4) pressed[8] = ~pressed[8];
        end
        next_tick();
        chk("bounce_valid", key_valid, 1);
        chk("bounce_code",  key_code,  8);
        pop_one(4'd8);
        chk("bounce_one_event", key_valid, 0);

        // Ghosting: rows 0 and 2 together on column 1.
        pressed = '0;
        do_reset();
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            next_tick();
            chk("ghost_col",   columnas,  4'b0001 << (t % 4));
            chk("ghost_valid", key_valid, 0);
            chk("ghost_held",  key_held,  0);
        end

        // Overflow with no consumer, then full FIFO with a pop on the fifth push.
        run_five(1'b0);
        run_five(1'b1);

        // Reset while a key is held; the key stays down and must be confirmed afresh.
        pressed = '0;
        do_reset();
        pressed[6] = 1'b1;
        repeat (6) next_tick();
        chk("rh_held_before", key_held,  1);
        chk("rh_valid_before", key_valid, 1);
        do_reset();
        for (int t = 1; t <= 5; t++) begin
            next_tick();
            chk("rh_no_event", key_valid, 0);
        end
        next_tick();
        chk("rh_reconfirm_valid", key_valid, 1);
        chk("rh_reconfirm_code",  key_code,  6);
        chk("rh_reconfirm_held",  key_held,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning number of keypad row inputs (2..8).
REQ-002 SHALL have parameter COLS, default 4, meaning number of keypad column outputs (2..8).
REQ-003 SHALL have parameter DWELL_CYCLES, default 27_000, meaning clk cycles per column dwell (1 ms at 27 MHz).
REQ-004 SHALL have parameter DB_SAMPLES, default 4, meaning consecutive identical dwell-end samples needed to accept a press or release.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning key-event FIFO entries (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, meaning the single system clock.
REQ-007 SHALL have port n_reset, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port filas_raw, input, ROWS, meaning asynchronous active-high row lines.
REQ-009 SHALL have port columnas, output, COLS, meaning one-hot active-high column drive.
REQ-010 SHALL have port key_code, output, KW=$clog2(ROWS*COLS), meaning FIFO head key index.
REQ-011 SHALL have port key_valid, output, 1, meaning FIFO non-empty.
REQ-012 SHALL have port key_ready, input, 1, meaning consumer accepts head when key_valid && key_ready.
REQ-013 SHALL have port key_held, output, 1, meaning a debounced key is currently down.
REQ-014 SHALL have port overflow, output, 1, meaning sticky: a press was dropped because the FIFO was full.

Function
REQ-015 SHALL pass filas_raw through a 2-flop synchroniser before any use.
REQ-016 SHALL generate a dwell tick every DWELL_CYCLES clk cycles from a free-running counter that wraps to 0.
REQ-017 SHALL implement FSM states SCAN, CONFIRM, HELD, RELEASE.
REQ-018 SCAN: on tick with synced rows == 0, SHALL rotate columnas to the next bit (bit COLS-1 wraps to bit 0); with exactly one row set, SHALL latch row/col and go CONFIRM without rotating.
REQ-019 SCAN: with more than one row set (ghost/multi-press), SHALL stay in SCAN and rotate columnas as if no row were set.
REQ-020 CONFIRM: SHALL count ticks where rows equal the latched one-hot pattern; at count DB_SAMPLES, SHALL go HELD; on any mismatching tick, SHALL return to SCAN with the count cleared.
REQ-021 On the CONFIRM->HELD transition, SHALL push key_code = row*COLS + col in the same cycle.
REQ-022 HELD: SHALL keep columnas frozen, assert key_held, go RELEASE on the first tick with rows == 0, and push no further events.
REQ-023 RELEASE: SHALL return to SCAN after DB_SAMPLES consecutive zero-row ticks (rotating columnas on that tick), or to HELD on any tick with the latched row set.
REQ-024 The FIFO SHALL be first-word-fall-through: key_code is valid combinationally from the head whenever key_valid = 1.
REQ-025 Simultaneous push and pop on a full FIFO SHALL succeed with no loss.
REQ-026 A push to a full FIFO without a pop SHALL be dropped and SHALL set overflow.
REQ-027 Pop on empty SHALL be ignored.

Reset
REQ-028 While n_reset = 0, SHALL set: state SCAN; columnas = bit 0 one-hot; tick and debounce counters 0; FIFO empty (key_valid = 0, key_code = 0); key_held = 0; overflow = 0; synchroniser flops 0.
REQ-029 Reset asserted mid-CONFIRM or mid-HELD SHALL discard the pending or held key without a push.
REQ-030 Only reset SHALL clear overflow.

Structure
REQ-031 A shared package keypad_pkg SHALL hold the FSM state enum and the key-index width function.
REQ-032 The FIFO SHALL be a separate sub-module, key_fifo, parameterised on depth and width; everything else SHALL stay in keypad_scan_ctrl.

Verification (DWELL_CYCLES=8, DB_SAMPLES=3, FIFO_DEPTH=4, 4x4)
REQ-033 SHALL cover single press: row 1 held high while column 2 is driven -> one event key_code = 6; key_held = 1 until release is debounced.
REQ-034 SHALL cover bounce: row toggling every tick for 5 ticks, then stable -> exactly one event, no spurious early push.
REQ-035 SHALL cover ghosting: rows 0 and 2 set together on column 1 -> no event; columnas keeps rotating.
REQ-036 SHALL cover overflow: 5 distinct presses with key_ready = 0 -> FIFO holds the first 4 codes in order, overflow = 1; popping yields exactly those 4.
REQ-037 SHALL cover full-FIFO push with simultaneous pop: key_ready = 1 during the 5th push -> no drop, overflow = 0.
REQ-038 SHALL cover reset during HELD: n_reset pulsed low -> key_valid = 0, columnas = 4'b0001, no event after reset while the key stays down until confirmed again.
